mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage pipeline.
- Replaces the separate instruction and data memories, so programs assembled for a von Neumann layout run unmodified.
- Fixed-latency memory accesses are sequenced with a request/ack handshake on each port.
- Asserts a pipeline stall while any request is outstanding.

Parameters:
- LATENCY, 2: memory cycles per access, range 1..15; mem_rdata is valid on the last cycle.
- ADDR_W, 14: word-address width driven to memory.
- STARVE_MAX, 3: maximum consecutive data grants while if_req is pending; the next grant is forced to IF.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word; registered, valid from the if_ack cycle until the next IF completion.
- if_ack  out  1  one-cycle pulse when a fetch completes.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data; registered, same validity rule as if_rdata.
- dm_ack  out  1  one-cycle pulse when a data access completes.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data.
- stall  out  1  high while any request is pending and not yet acked.
- grant_dm  out  1  1 = current or last grant belongs to the data port.

Behaviour:
- States: IDLE, ACCESS.
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0, including the rdata registers; the starve counter clears.
  - mem_en and mem_we drop immediately, with no clock edge needed.
  - An access in flight is abandoned and no ack is issued.
  - After reset releases, pending requests are re-arbitrated from IDLE.
- IDLE arbitration, evaluated each cycle:
  - dm_req has priority over if_req, unless starve_cnt == STARVE_MAX and if_req=1, in which case IF wins.
  - On a grant, latch the port, address, we and wdata, then go to ACCESS with cyc=0.
  - With no request, remain in IDLE with mem_en=0.
- Starve counter:
  - Increments on every DM grant made while if_req=1, saturating at STARVE_MAX.
  - Clears on every IF grant, and on any DM grant made while if_req=0.
- ACCESS:
  - mem_en=1 and mem_addr = latched addr[ADDR_W+1:2]; addr[1:0] are ignored.
  - mem_we=1 only when cyc=0 and the latched we=1, so a store writes exactly once.
  - cyc counts 0..LATENCY-1.
  - When cyc=LATENCY-1:
    - For a load or fetch, capture mem_rdata into the granted port's rdata register.
    - For a store, the rdata registers are unchanged.
    - Pulse that port's ack on the next cycle and return to IDLE.
- Latency: a request seen in IDLE at edge N gives an ack high during cycle N+LATENCY+1. Back-to-back accesses are possible: arbitration happens in the same cycle as the ack, because IDLE is re-entered on that edge.
- Handshake violations:
  - A req dropped after grant still completes and still acks.
  - A req not held high while in IDLE is not served.
  - Inputs are not sampled after the grant; changes during ACCESS have no effect.
- Simultaneous ack and new req on the same port: the ack is for the old access, and the new req is arbitrated in that same cycle.
- stall = (if_req & ~if_ack) | (dm_req & ~dm_ack), combinational.
- grant_dm is updated at grant time and held until the next grant.

Test Plan:
- Single fetch, LATENCY=2: if_req=1 with if_addr=0x00000010 at cycle 0 -> mem_addr=4 with mem_en high in cycles 1-2, if_ack pulses in cycle 3, if_rdata equals the memory word, stall=1 in cycles 0-2.
- Simultaneous if_req and dm_req (load at 0x40) -> DM served first (grant_dm=1, dm_ack in cycle 3), then IF granted in cycle 3 with if_ack in cycle 6.
- Store 0xDEADBEEF to 0x80, then load 0x80 -> mem_we high for exactly one cycle, and the load returns dm_rdata=0xDEADBEEF.
- Starvation, STARVE_MAX=3: dm_req held high continuously and if_req high -> 3 DM grants, then 1 IF grant, then DM resumes; starve_cnt returns to 0.
- Reset at cycle 2 of a store access -> mem_we and mem_en go low asynchronously, no dm_ack, all outputs 0; after release with dm_req still high, the store reissues and completes normally.
- Fetch req dropped in cycle 1 after grant -> access completes, if_ack still pulses in cycle 3, and no second access starts.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port fixed-latency memory between the IF and MEM pipeline ports.
// Data port wins by default; a starvation counter forces an IF grant after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic              grant_dm
);

  localparam int unsigned CYC_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_d;
  logic [CYC_W-1:0]  cyc, cyc_d;
  logic [CNT_W-1:0]  starve_cnt, starve_d;
  logic              lat_we;
  logic              start;
  logic              pick_dm;
  logic              done;

  // Byte-offset and upper address bits never reach the word-addressed memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              dm_addr[31:ADDR_W+2], dm_addr[1:0]};

  // Next-state, arbitration and starvation bookkeeping.
  always_comb begin
    state_d  = state;
    cyc_d    = cyc;
    starve_d = starve_cnt;
    start    = 1'b0;
    pick_dm  = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req || if_req) begin
          start   = 1'b1;
          pick_dm = dm_req && !(if_req && (starve_cnt == CNT_MAX));
          state_d = ACCESS;
          cyc_d   = '0;
          if (!pick_dm || !if_req)     starve_d = '0;
          else if (starve_cnt < CNT_MAX) starve_d = starve_cnt + CNT_W'(1);
        end
      end
      ACCESS: begin
        if (cyc == LAST_CYC) begin
          done    = 1'b1;
          state_d = IDLE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc + CYC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cyc        <= '0;
      starve_cnt <= '0;
      lat_we     <= 1'b0;
      grant_dm   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      state      <= state_d;
      cyc        <= cyc_d;
      starve_cnt <= starve_d;
      if_ack     <= done && !grant_dm;
      dm_ack     <= done && grant_dm;
      // Write strobe only on the first access cycle so a store lands once.
      mem_we     <= start && pick_dm && dm_we;
      if (start) begin
        grant_dm  <= pick_dm;
        lat_we    <= pick_dm && dm_we;
        mem_en    <= 1'b1;
        mem_addr  <= pick_dm ? dm_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
        mem_wdata <= pick_dm ? dm_wdata : 32'h0;
      end else if (done) begin
        mem_en <= 1'b0;
      end
      if (done && !lat_we) begin
        if (grant_dm) dm_rdata <= mem_rdata;
        else          if_rdata <= mem_rdata;
      end
    end
  end

  assign stall = (if_req && !if_ack) || (dm_req && !dm_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a word-addressed memory model; cycle k starts at the k-th rising edge.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_en;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        grant_dm;

  int checks = 0;
  int errors = 0;
  int n;
  logic [7:0] exp_seq;

  logic [31:0] mem [0:16383];

  mem_arbiter #(.LATENCY(2), .ADDR_W(14), .STARVE_MAX(3)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall), .grant_dm(grant_dm)
  );

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clock) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'h1111_2222;
    mem[8]  = 32'h5555_6666;
    mem[16] = 32'h3333_4444;

    // Reset state
    #3;
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_if_ack", 32'(if_ack), 32'h0);
    check("rst_grant_dm", 32'(grant_dm), 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    tick();
    reset = 1'b1;

    // Single fetch of 0x10
    tick();
    if_req = 1'b1; if_addr = 32'h10;
    #1 check("f_stall_c0", 32'(stall), 32'h1);
    tick();
    check("f_en_c1", 32'(mem_en), 32'h1);
    check("f_addr_c1", 32'(mem_addr), 32'h4);
    check("f_stall_c1", 32'(stall), 32'h1);
    tick();
    check("f_en_c2", 32'(mem_en), 32'h1);
    check("f_ack_c2", 32'(if_ack), 32'h0);
    tick();
    check("f_ack_c3", 32'(if_ack), 32'h1);
    check("f_rdata_c3", if_rdata, 32'h1111_2222);
    check("f_stall_c3", 32'(stall), 32'h0);
    check("f_en_c3", 32'(mem_en), 32'h0);
    if_req = 1'b0;
    tick();
    check("f_ack_c4", 32'(if_ack), 32'h0);
    check("f_en_c4", 32'(mem_en), 32'h0);

    // Simultaneous fetch (0x20) and load (0x40): data first
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    tick();
    check("s_grant_c1", 32'(grant_dm), 32'h1);
    check("s_addr_c1", 32'(mem_addr), 32'h10);
    tick();
    tick();
    check("s_dmack_c3", 32'(dm_ack), 32'h1);
    check("s_dmrd_c3", dm_rdata, 32'h3333_4444);
    check("s_ifack_c3", 32'(if_ack), 32'h0);
    dm_req = 1'b0;
    tick();
    check("s_grant_c4", 32'(grant_dm), 32'h0);
    check("s_addr_c4", 32'(mem_addr), 32'h8);
    check("s_dmack_c4", 32'(dm_ack), 32'h0);
    tick();
    check("s_ifack_c5", 32'(if_ack), 32'h0);
    tick();
    check("s_ifack_c6", 32'(if_ack), 32'h1);
    check("s_ifrd_c6", if_rdata, 32'h5555_6666);
    if_req = 1'b0;
    tick();

    // Store 0xDEADBEEF to 0x80 then load it back
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hDEAD_BEEF;
    tick();
    check("st_we_c1", 32'(mem_we), 32'h1);
    check("st_addr_c1", 32'(mem_addr), 32'h20);
    check("st_wd_c1", mem_wdata, 32'hDEAD_BEEF);
    tick();
    check("st_we_c2", 32'(mem_we), 32'h0);
    tick();
    check("st_ack_c3", 32'(dm_ack), 32'h1);
    check("st_rd_kept", dm_rdata, 32'h3333_4444);
    dm_we = 1'b0;
    tick();
    check("ld_we_c4", 32'(mem_we), 32'h0);
    check("ld_en_c4", 32'(mem_en), 32'h1);
    tick();
    tick();
    check("ld_ack", 32'(dm_ack), 32'h1);
    check("ld_rd", dm_rdata, 32'hDEAD_BEEF);
    dm_req = 1'b0;
    tick();

    // Starvation: both held, expect D D D I D D D I (bit k = data)
    exp_seq = 8'b0111_0111;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    if_req = 1'b1; if_addr = 32'h20;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!(if_ack || dm_ack) && n < 10) begin
        tick();
        n++;
      end
      check("starve_ack_seen", 32'(if_ack || dm_ack), 32'h1);
      check("starve_order", 32'(dm_ack), 32'(exp_seq[k]));
      if (k == 7) begin
        dm_req = 1'b0;
        if_req = 1'b0;
      end
      tick();
    end
    tick();

    // Reset during a store to 0x84
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h84; dm_wdata = 32'hCAFE_F00D;
    tick();
    check("rs_we_c1", 32'(mem_we), 32'h1);
    tick();
    check("rs_en_c2", 32'(mem_en), 32'h1);
    reset = 1'b0;
    #1;
    check("rs_en_async", 32'(mem_en), 32'h0);
    check("rs_we_async", 32'(mem_we), 32'h0);
    check("rs_grant", 32'(grant_dm), 32'h0);
    check("rs_addr", 32'(mem_addr), 32'h0);
    check("rs_dmrd", dm_rdata, 32'h0);
    check("rs_ifrd", if_rdata, 32'h0);
    tick();
    check("rs_no_ack", 32'(dm_ack), 32'h0);
    reset = 1'b1;
    tick();
    check("rs2_we_c1", 32'(mem_we), 32'h1);
    check("rs2_addr_c1", 32'(mem_addr), 32'h21);
    check("rs2_grant", 32'(grant_dm), 32'h1);
    tick();
    tick();
    check("rs2_ack", 32'(dm_ack), 32'h1);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    check("rs2_mem", mem[33], 32'hCAFE_F00D);

    // Fetch whose request is dropped right after grant
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    if_req = 1'b0;
    #1 check("dr_stall_c1", 32'(stall), 32'h0);
    check("dr_en_c1", 32'(mem_en), 32'h1);
    tick();
    tick();
    check("dr_ack_c3", 32'(if_ack), 32'h1);
    check("dr_rd_c3", if_rdata, 32'h1111_2222);
    tick();
    check("dr_ack_c4", 32'(if_ack), 32'h0);
    check("dr_en_c4", 32'(mem_en), 32'h0);
    tick();
    check("dr_en_c5", 32'(mem_en), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
